fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter_pkg.sv | 13 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 37 +++
 rtl/fifo_wr_arbiter.sv | 112 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_wr_arbiter_pkg;

  localparam int unsigned DEF_DSIZE     = 8;
  localparam int unsigned DEF_NREQ      = 4;
  localparam int unsigned DEF_MAX_BURST = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr_i.
module rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter  int unsigned NREQ = DEF_NREQ,
  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] rr_ptr_i,
  output logic [NREQ-1:0] winner_o,
  output logic [IDXW-1:0] winner_idx_o,
  output logic            any_o
);

  // Scan from the farthest offset down so the nearest hit to rr_ptr_i wins.
  always_comb begin
    int            idx;
    logic [IDXW-1:0] sel;
    winner_o     = '0;
    winner_idx_o = '0;
    any_o        = 1'b0;
    idx          = 0;
    sel          = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_i) + k;
      if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
      sel = IDXW'(idx);
      if (req_i[sel]) begin
        winner_o      = '0;
        winner_o[sel] = 1'b1;
        winner_idx_o  = sel;
        any_o         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding a single FIFO write port from NREQ requesters.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter  int unsigned DSIZE     = DEF_DSIZE,
  parameter  int unsigned NREQ      = DEF_NREQ,
  parameter  int unsigned MAX_BURST = DEF_MAX_BURST,
  localparam int unsigned IDXW      = $clog2(NREQ)
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       gnt,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [DSIZE-1:0]      fifo_wr_data,
  output logic                  busy
);

  localparam int unsigned CNTW = $clog2(MAX_BURST) + 1;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [NREQ-1:0]   owner_oh_q, owner_oh_d;
  logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNTW-1:0]   beat_cnt_q, beat_cnt_d;

  logic [NREQ-1:0]   pick_oh;
  logic [IDXW-1:0]   pick_idx;
  logic              pick_any;
  logic [IDXW-1:0]   next_ptr;
  logic [CNTW-1:0]   cnt_inc;
  logic              own_req;
  logic              own_last;
  logic [DSIZE-1:0]  beat_data [NREQ];

  for (genvar i = 0; i < int'(NREQ); i++) begin : g_slice
    assign beat_data[i] = req_data[i*DSIZE +: DSIZE];
  end

  rr_pick #(
    .NREQ(NREQ)
  ) u_rr_pick (
    .req_i        (req),
    .rr_ptr_i     (rr_ptr_q),
    .winner_o     (pick_oh),
    .winner_idx_o (pick_idx),
    .any_o        (pick_any)
  );

  assign next_ptr = (owner_q == IDXW'(NREQ - 1)) ? '0 : owner_q + IDXW'(1);
  assign cnt_inc  = beat_cnt_q + CNTW'(1);
  assign own_req  = |(req & owner_oh_q);
  assign own_last = |(req_last & owner_oh_q);
  assign busy     = (state_q == ST_BURST);

  // Next-state and combinational write-port drive; reset suppresses any write.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    owner_oh_d   = owner_oh_q;
    rr_ptr_d     = rr_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    gnt          = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d    = ST_BURST;
          owner_d    = pick_idx;
          owner_oh_d = pick_oh;
          beat_cnt_d = '0;
        end
      end
      ST_BURST: begin
        if (!own_req) begin
          state_d  = ST_IDLE;
          rr_ptr_d = next_ptr;
        end else if (!fifo_full && !wr_rst) begin
          gnt          = owner_oh_q;
          fifo_wr_en   = 1'b1;
          fifo_wr_data = beat_data[owner_q];
          beat_cnt_d   = cnt_inc;
          if (own_last || (cnt_inc == CNTW'(MAX_BURST))) begin
            state_d  = ST_IDLE;
            rr_ptr_d = next_ptr;
          end
        end
      end
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      owner_oh_q <= NREQ'(1);
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      owner_oh_q <= owner_oh_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios plus a random soak.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DSIZE = 8;
  localparam int MAXB  = 4;

  logic                  wr_clk = 1'b0;
  logic                  wr_rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       gnt;
  logic                  fifo_full;
  logic                  fifo_wr_en;
  logic [DSIZE-1:0]      fifo_wr_data;
  logic                  busy;

  fifo_wr_arbiter #(
    .DSIZE    (DSIZE),
    .NREQ     (NREQ),
    .MAX_BURST(MAXB)
  ) dut (
    .wr_clk      (wr_clk),
    .wr_rst      (wr_rst),
    .req         (req),
    .req_data    (req_data),
    .req_last    (req_last),
    .gnt         (gnt),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .busy        (busy)
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct packed {
    logic [NREQ-1:0]  gnt;
    logic             en;
    logic [DSIZE-1:0] data;
    logic             busy;
  } exp_t;

  exp_t sb_q[$];
  int   seq_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_cnt   = 0;

  logic [NREQ-1:0]  s_gnt;
  logic             s_en;
  logic [DSIZE-1:0] s_data;
  logic             s_busy;
  logic [NREQ-1:0]  prev_gnt = '0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step(input logic [NREQ-1:0] r, input logic [31:0] d,
                      input logic [NREQ-1:0] l, input logic f, input logic rs);
    exp_t e;
    exp_t got;
    bit   found;
    @(posedge wr_clk);
    #1;
    req = r; req_data = d; req_last = l; fifo_full = f; wr_rst = rs;
    e      = '0;
    e.busy = m_busy;
    if (!rs && m_busy && r[m_owner] && !f) begin
      e.gnt  = NREQ'(1 << m_owner);
      e.en   = 1'b1;
      e.data = d[m_owner*DSIZE +: DSIZE];
    end
    sb_q.push_back(e);

    @(negedge wr_clk);
    s_gnt = gnt; s_en = fifo_wr_en; s_data = fifo_wr_data; s_busy = busy;
    got = sb_q.pop_front();
    check_val("gnt",  32'(s_gnt),  32'(got.gnt));
    check_val("wr_en", 32'(s_en),  32'(got.en));
    check_val("wr_data", 32'(s_data), 32'(got.data));
    check_val("busy", 32'(s_busy), 32'(got.busy));
    check_val("gnt_onehot0", 32'($onehot0(s_gnt)), 32'd1);
    check_val("gnt_while_full", 32'(f && (s_gnt != '0)), 32'd0);

    if (s_gnt != '0 && prev_gnt == '0)
      for (int i = 0; i < NREQ; i++) if (s_gnt[i]) seq_q.push_back(i);
    prev_gnt = s_gnt;

    if (rs) begin
      m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    end else if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        if (!found && r[(m_ptr + k) % NREQ]) begin
          found   = 1'b1;
          m_owner = (m_ptr + k) % NREQ;
        end
      end
      if (found) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else if (!r[m_owner]) begin
      m_busy = 1'b0;
      m_ptr  = (m_owner + 1) % NREQ;
    end else if (!f) begin
      m_cnt++;
      if (l[m_owner] || m_cnt == MAXB) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % NREQ;
      end
    end
  endtask

  initial begin
    wr_rst = 1'b1; req = '0; req_data = '0; req_last = '0; fifo_full = 1'b0;
    repeat (2) @(posedge wr_clk);
    step('0, 0, '0, 1'b0, 1'b1);
    check_val("reset_busy", 32'(s_busy), 32'd0);

    // Single last-beat packet from requester 2
    step(4'b0100, 32'h00A5_0000, 4'b0100, 1'b0, 1'b0);
    check_val("t030_idle_gnt", 32'(s_gnt), 32'd0);
    check_val("t030_idle_en", 32'(s_en), 32'd0);
    step(4'b0100, 32'h00A5_0000, 4'b0100, 1'b0, 1'b0);
    check_val("t030_gnt", 32'(s_gnt), 32'b0100);
    check_val("t030_data", 32'(s_data), 32'hA5);
    step('0, 0, '0, 1'b0, 1'b0);
    check_val("t030_busy_after", 32'(s_busy), 32'd0);
    step(4'b1111, $urandom, '0, 1'b0, 1'b0);
    step(4'b1111, $urandom, '0, 1'b0, 1'b0);
    check_val("t030_ptr3", 32'(s_gnt), 32'b1000);

    // All requesters busy: full 4-beat bursts rotating from 0
    step('0, 0, '0, 1'b0, 1'b1);
    seq_q.delete();
    prev_gnt = '0;
    repeat (26) step(4'b1111, $urandom, '0, 1'b0, 1'b0);
    check_val("t031_nbursts", 32'(seq_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < seq_q.size(); i++)
      check_val("t031_order", 32'(seq_q[i]), 32'(i % NREQ));

    // Stall mid-burst on FIFO full
    step('0, 0, '0, 1'b0, 1'b1);
    step(4'b0010, $urandom, '0, 1'b0, 1'b0);
    repeat (2) step(4'b0010, $urandom, '0, 1'b0, 1'b0);
    repeat (5) begin
      step(4'b0010, $urandom, '0, 1'b1, 1'b0);
      check_val("t032_stall_gnt", 32'(s_gnt), 32'd0);
      check_val("t032_stall_en", 32'(s_en), 32'd0);
    end
    repeat (2) begin
      step(4'b0010, $urandom, '0, 1'b0, 1'b0);
      check_val("t032_resume_gnt", 32'(s_gnt), 32'b0010);
    end
    step(4'b0010, $urandom, '0, 1'b0, 1'b0);
    check_val("t032_done_busy", 32'(s_busy), 32'd0);

    // Owner 3 abandons after one beat
    step('0, 0, '0, 1'b0, 1'b1);
    step(4'b1000, $urandom, '0, 1'b0, 1'b0);
    step(4'b1000, $urandom, '0, 1'b0, 1'b0);
    check_val("t033_beat1", 32'(s_gnt), 32'b1000);
    step(4'b0000, $urandom, '0, 1'b0, 1'b0);
    step(4'b1001, $urandom, '0, 1'b0, 1'b0);
    check_val("t033_idle", 32'(s_busy), 32'd0);
    step(4'b1001, $urandom, '0, 1'b0, 1'b0);
    check_val("t033_next_owner", 32'(s_gnt), 32'b0001);

    // Reset during beat 2
    step('0, 0, '0, 1'b0, 1'b1);
    step(4'b0001, $urandom, '0, 1'b0, 1'b0);
    step(4'b0001, $urandom, '0, 1'b0, 1'b0);
    step(4'b0001, $urandom, '0, 1'b0, 1'b1);
    check_val("t034_rst_en", 32'(s_en), 32'd0);
    step(4'b1111, $urandom, '0, 1'b0, 1'b0);
    check_val("t034_post_busy", 32'(s_busy), 32'd0);
    check_val("t034_post_gnt", 32'(s_gnt), 32'd0);
    step(4'b1111, $urandom, '0, 1'b0, 1'b0);
    check_val("t034_restart", 32'(s_gnt), 32'b0001);

    // Random soak
    step('0, 0, '0, 1'b0, 1'b1);
    repeat (1000)
      step(NREQ'($urandom) | NREQ'($urandom), $urandom,
           NREQ'($urandom) & NREQ'($urandom),
           ($urandom_range(0, 3) == 0), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
